// File: rtl/mem_access_unit_if.sv
// -----------------------------------------------------------------------------
// mem_access_unit_if
//
// Purpose: bundles the request/response handshake of the load/store unit and
// its word-indexed data memory port into one interface.
//
// Signals:
//   req_valid / req_ready    request handshake (accept when both high)
//   req_write                1 = store, 0 = load
//   req_size                 0 = byte, 1 = halfword, 2/3 = word
//   req_signed               loads: 1 = sign-extend, 0 = zero-extend
//   req_addr [ADDR_W]        byte address
//   req_wdata [32]           store data, sub-word data in the low bits
//   resp_valid               one-cycle completion pulse
//   resp_rdata [32]          extended load data, 0 for stores
//   resp_error               misaligned-access flag, valid with resp_valid
//   mem_write_enable         data memory write strobe
//   mem_address [32]         word index into the data memory
//   mem_write_data [32]      full word to write
//   mem_read_data [32]       combinational read of mem_address
//
// Modports:
//   slave  - the load/store unit
//   master - the requester / memory side (testbench)
// -----------------------------------------------------------------------------
interface mem_access_unit_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_error;
   logic              mem_write_enable;
   logic [31:0]       mem_address;
   logic [31:0]       mem_write_data;
   logic [31:0]       mem_read_data;

   modport slave (
      input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      input  mem_read_data,
      output req_ready, resp_valid, resp_rdata, resp_error,
      output mem_write_enable, mem_address, mem_write_data
   );

   modport master (
      output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
      output mem_read_data,
      input  req_ready, resp_valid, resp_rdata, resp_error,
      input  mem_write_enable, mem_address, mem_write_data
   );
endinterface

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose: load/store initiator between the MIPS execute/memory stage and a
// word-wide data memory (combinational read, clocked write). One request at a
// time: lw/lh/lhu/lb/lbu/sw/sh/sb. Sub-word stores are done as
// read-modify-write; loads return a one-cycle response pulse with sign- or
// zero-extended data. Little-endian lane ordering.
//
// Parameters:
//   ADDR_W  byte-address width of requests
//   MEM_AW  word-index width used by the data memory (index wraps mod 2^MEM_AW)
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      mem_access_unit_if.slave (request, response and memory port)
//
// Build option:
//   MEM_ACCESS_MISALIGN_TRAP_EN  when defined, a misaligned halfword/word
//   request completes through ERR with resp_error = 1 and no memory access.
//   When undefined, misaligned low address bits are forced to alignment and
//   resp_error is tied 0.
// -----------------------------------------------------------------------------
module mem_access_unit #(
   parameter int ADDR_W = 32,
   parameter int MEM_AW = 8
) (
   input  logic              clock,
   input  logic              reset_n,
   mem_access_unit_if.slave  bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RMW_READ,
      S_WRITE,
      S_RESP,
      S_ERR
   } state_t;

   state_t state_q, state_d;

   // Only the byte-offset and word-index bits are meaningful to the memory.
   logic [MEM_AW+1:0] addr_q;
   logic [1:0]        size_q;
   logic              signed_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic [31:0]       merged_q;

   logic              accept;
   logic              trap_req;
   logic              ready_c;
   logic              resp_valid_c;
   logic              write_en_c;

   // Upper address bits are intentionally ignored (word index wraps).
   logic              unused_addr_hi;
   assign unused_addr_hi = ^bus.req_addr[ADDR_W-1:MEM_AW+2];

   // --------------------------------------------------------------------------
   // Helper functions
   // --------------------------------------------------------------------------

   // Halfword with addr[0] set, or word with any low bit set.
   function automatic logic is_misaligned(input logic [1:0] low,
                                          input logic [1:0] size);
      logic r;
      r = 1'b0;
      if (size == 2'd1)
         r = low[0];
      else if (size[1])
         r = (low != 2'b00);
      return r;
   endfunction

   // Force the low address bits to the natural alignment of the access size.
   function automatic logic [MEM_AW+1:0] align_addr(input logic [MEM_AW+1:0] a,
                                                    input logic [1:0]        size);
      logic [MEM_AW+1:0] r;
      r = a;
      if (size == 2'd1)
         r[0] = 1'b0;
      else if (size[1])
         r[1:0] = 2'b00;
      return r;
   endfunction

   // Select the addressed lane(s) from a memory word and extend to 32 bits.
   function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size,
                                                input logic        sgn);
      logic [31:0] shifted;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      shifted = word >> {lane, 3'b000};
      b       = shifted[7:0];
      h       = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'd0:    r = {{24{sgn & b[7]}}, b};
         2'd1:    r = {{16{sgn & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace the addressed lane(s) of a memory word with the store data.
   function automatic logic [31:0] merge_store(input logic [31:0] word,
                                               input logic [31:0] wd,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size);
      logic [31:0] r;
      r = word;
      case (size)
         2'd0: begin
            case (lane)
               2'd0:    r[7:0]   = wd[7:0];
               2'd1:    r[15:8]  = wd[7:0];
               2'd2:    r[23:16] = wd[7:0];
               default: r[31:24] = wd[7:0];
            endcase
         end
         2'd1: begin
            if (lane[1])
               r[31:16] = wd[15:0];
            else
               r[15:0]  = wd[15:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   // --------------------------------------------------------------------------
   // Misalignment policy
   // --------------------------------------------------------------------------
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
   assign trap_req       = is_misaligned(bus.req_addr[1:0], bus.req_size);
   assign bus.resp_error = (state_q == S_ERR);
`else
   assign trap_req       = 1'b0;
   assign bus.resp_error = 1'b0;
`endif

   assign accept = bus.req_valid && (state_q == S_IDLE);

   // --------------------------------------------------------------------------
   // Stage boundary: FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state and control outputs
   always_comb begin
      state_d      = state_q;
      ready_c      = 1'b0;
      resp_valid_c = 1'b0;
      write_en_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            if (bus.req_valid) begin
               if (trap_req)
                  state_d = S_ERR;
               else if (!bus.req_write)
                  state_d = S_LOAD;
               else if (bus.req_size[1])
                  state_d = S_WRITE;
               else
                  state_d = S_RMW_READ;
            end
         end
         S_LOAD:     state_d = S_RESP;
         S_RMW_READ: state_d = S_WRITE;
         S_WRITE: begin
            write_en_c = 1'b1;
            state_d    = S_RESP;
         end
         S_RESP: begin
            resp_valid_c = 1'b1;
            state_d      = S_IDLE;
         end
         S_ERR: begin
            resp_valid_c = 1'b1;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // --------------------------------------------------------------------------
   // Stage boundary: request capture, load extraction, RMW merge
   // --------------------------------------------------------------------------
   // Data registers are reset too, so that every memory-side output shows its
   // idle value immediately on reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_q   <= '0;
         size_q   <= 2'd0;
         signed_q <= 1'b0;
         wdata_q  <= 32'd0;
         rdata_q  <= 32'd0;
         merged_q <= 32'd0;
      end else begin
         if (accept) begin
            addr_q   <= align_addr(bus.req_addr[MEM_AW+1:0], bus.req_size);
            size_q   <= bus.req_size;
            signed_q <= bus.req_signed;
            wdata_q  <= bus.req_wdata;
            // Stores and traps report zero data.
            rdata_q  <= 32'd0;
         end
         if (state_q == S_LOAD)
            rdata_q <= extract_load(bus.mem_read_data, addr_q[1:0], size_q, signed_q);
         if (state_q == S_RMW_READ)
            merged_q <= merge_store(bus.mem_read_data, wdata_q, addr_q[1:0], size_q);
      end
   end

   // --------------------------------------------------------------------------
   // Stage boundary: outputs
   // --------------------------------------------------------------------------
   assign bus.req_ready        = ready_c;
   assign bus.resp_valid       = resp_valid_c;
   assign bus.resp_rdata       = (state_q == S_RESP) ? rdata_q : 32'd0;
   assign bus.mem_write_enable = write_en_c;
   assign bus.mem_address      = {{(32-MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};
   assign bus.mem_write_data   = (state_q == S_WRITE) ?
                                 (size_q[1] ? wdata_q : merged_q) : 32'd0;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MIPS execute/memory stage and the word-wide data memory. It accepts one byte-addressed request at a time: lw, lh, lhu, lb, lbu, sw, sh or sb. It drives the data memory's word-indexed port, which has a combinational read and a clocked write. Sub-word stores use a read-modify-write sequence; loads return sign- or zero-extended data with a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of requests.
- MEM_AW, 8, word-index width actually used by the data memory (256 words).

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data; sub-word data sits in the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores.
- resp_error  out  1  misaligned access; valid with resp_valid.
- mem_write_enable  out  1  data memory write strobe.
- mem_address  out  32  word index = {zeros, addr_q[MEM_AW+1:2]}.
- mem_write_data  out  32  full word to write.
- mem_read_data  in  32  combinational read of mem_address.

## Operation
- A request is accepted on a rising edge where req_valid && req_ready. All fields are captured into registers (addr_q, size_q, etc.); inputs are then ignored until the next IDLE.
- Endianness is little: byte lane k = addr_q[1:0] occupies bits [8k+7:8k]. A halfword at addr_q[1] = h occupies bits [16h+15:16h].
- States: IDLE, LOAD, RMW_READ, WRITE, RESP, ERR.
- IDLE transitions on accept:
  - misaligned and trap enabled → ERR;
  - load → LOAD;
  - word store → WRITE;
  - sub-word store → RMW_READ.
- LOAD: mem_address is driven. At the end of the cycle, mem_read_data is captured, the lane is selected and extended into resp_rdata. Next state is RESP.
- RMW_READ: mem_address is driven. At the end of the cycle, the merged word is captured: mem_read_data with the target lane(s) replaced by req_wdata[7:0] or [15:0]. Next state is WRITE.
- WRITE: mem_write_enable = 1. mem_write_data is the merged word, or req_wdata for a word store. Next state is RESP.
- RESP: resp_valid = 1, resp_error = 0. Next state is IDLE.
- ERR: resp_valid = 1, resp_error = 1, resp_rdata = 0; no memory access is made. Next state is IDLE.
- resp_valid has no backpressure; the consumer must sample it in the pulse cycle.
- Address bits above MEM_AW+1 are ignored; the word index wraps modulo 2^MEM_AW.

## Timing
- Reset (asynchronous, immediate): state IDLE, req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_error = 0, mem_write_enable = 0, mem_address = 0, mem_write_data = 0.
- Latency from the accept edge (cycle 0) to the resp_valid cycle:
  - load: 2 (LOAD, RESP);
  - word store: 2 (WRITE, RESP);
  - sub-word store: 3 (RMW_READ, WRITE, RESP);
  - misaligned with trap: 1 (ERR).
- The memory write occurs on the rising edge that ends the WRITE cycle; data is visible to a read in RESP.
- req_ready is low from the cycle after accept through the RESP/ERR cycle. The next accept is possible in the first IDLE cycle after RESP, so there is no back-to-back overlap.
- mem_write_enable is high for exactly one cycle per store and never during loads or ERR.
- Reset asserted mid-operation:
  - it forces IDLE and drops mem_write_enable asynchronously;
  - a sub-word store reset before its WRITE edge leaves memory unmodified;
  - no resp_valid is produced for the aborted request.

## Configuration
- MEM_ACCESS_MISALIGN_TRAP_EN defined: a halfword with addr[0] = 1, or a word with addr[1:0] ≠ 0, goes to ERR; resp_error pulses with resp_valid.
- Not defined: misaligned low bits are forced to alignment. Halfword clears addr[0]; word clears addr[1:0]. Normal access follows, and resp_error is tied 0.

## Test plan
- Word round trip: sw 0xDEADBEEF to byte address 0x10, then lw 0x10 → mem_write_enable pulses once with mem_address = 4; the load resp_rdata = 0xDEADBEEF, 2 cycles after accept.
- Byte merge: memory word 4 = 0x11223344; sb 0xAA to 0x12 → word 4 becomes 0x11AA3344; sb resp_valid is 3 cycles after accept.
- Extension: word 4 = 0x80FF7F01; lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080; lh 0x10 → 0x00007F01; lh 0x12 → 0xFFFF80FF; lhu 0x12 → 0x000080FF.
- Misalignment with macro defined: lw 0x11 → ERR, resp_error = 1 and resp_rdata = 0 one cycle after accept, no mem_write_enable. Without the macro: same request returns word 4.
- Reset mid-RMW: sh 0xBEEF to 0x12, reset_n low during RMW_READ → all outputs at reset values immediately; word 4 is unchanged; req_ready = 1.
- Handshake: hold req_valid high with two queued requests → second accept only occurs after RESP of the first; req_ready is 0 in between.
